// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package : pipe_pkg
// Shared state encoding and defaults for the pipeline skid register.
// Rev     : 1.0
// ============================================================================
package pipe_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int STATE_W        = 2;

    typedef logic [STATE_W-1:0] state_t;

    // Encoding equals the number of held payloads, so occupancy is the state itself.
    localparam state_t ST_EMPTY = 2'd0;
    localparam state_t ST_BUSY  = 2'd1;
    localparam state_t ST_FULL  = 2'd2;

    function automatic logic [1:0] state_occupancy(input state_t s);
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_en_reg.sv
`default_nettype none
// ============================================================================
// Module : pipe_en_reg
// DATA_W-wide register with load enable and synchronous active-low reset.
// Rev    : 1.0
// ============================================================================
module pipe_en_reg #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module : pipe_skid_reg
// Two-entry skid pipeline stage: registered in_ready/out_valid, FIFO order, flush.
// Rev    : 1.0
// ============================================================================
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = DEFAULT_DATA_W,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    state_t            state_q;
    state_t            state_d;
    logic              in_ready_q;
    logic              in_ready_d;
    logic              out_valid_q;
    logic              out_valid_d;

    logic              w_accept;
    logic              w_pop;
    logic              w_main_load;
    logic              w_skid_load;
    logic [DATA_W-1:0] w_main_din;
    logic [DATA_W-1:0] w_main_q;
    logic [DATA_W-1:0] w_skid_q;

    assign w_accept = in_valid & in_ready_q;
    assign w_pop    = out_valid_q & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (w_accept) state_d = ST_BUSY;
                ST_BUSY: begin
                    if (w_accept && !w_pop) begin
                        state_d = ST_FULL;
                    end else if (w_pop && !w_accept) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL:  if (w_pop) state_d = ST_BUSY;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Handshake outputs are registered from the next state so they leave a flop.
    always_comb begin
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
        w_main_load = 1'b0;
        w_skid_load = 1'b0;
        w_main_din  = in_data;
        if (!flush) begin
            case (state_q)
                ST_EMPTY: w_main_load = w_accept;
                ST_BUSY: begin
                    w_main_load = w_accept & w_pop;
                    w_skid_load = w_accept & ~w_pop;
                end
                ST_FULL: begin
                    w_main_load = w_pop;
                    w_main_din  = w_skid_q;
                end
                default: begin
                    w_main_load = 1'b0;
                    w_skid_load = 1'b0;
                end
            endcase
        end
    end

    pipe_en_reg #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_main_load),
        .d     (w_main_din),
        .q     (w_main_q)
    );

    pipe_en_reg #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_skid_load),
        .d     (in_data),
        .q     (w_skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = w_main_q;
    assign occupancy = state_occupancy(state_q);

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_skid_reg
// Directed vector table plus random scoreboard run on 1/32/64-bit instances.
// Rev    : 1.0
// ============================================================================
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;
    logic        flush;

    logic        ir1, ov1, od1;
    logic [1:0]  occ1;
    logic        ir32, ov32;
    logic [31:0] od32;
    logic [1:0]  occ32;
    logic        ir64, ov64;
    logic [63:0] od64;
    logic [1:0]  occ64;

    pipe_skid_reg #(.DATA_W(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data[0]),
        .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_ready(out_ready),
        .flush(flush), .occupancy(occ1)
    );

    pipe_skid_reg #(.DATA_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data[31:0]),
        .in_ready(ir32), .out_valid(ov32), .out_data(od32), .out_ready(out_ready),
        .flush(flush), .occupancy(occ32)
    );

    pipe_skid_reg #(.DATA_W(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir64), .out_valid(ov64), .out_data(od64), .out_ready(out_ready),
        .flush(flush), .occupancy(occ64)
    );

    typedef struct {
        logic        rst_n;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic        ir;
        logic [1:0]  occ;
        logic [31:0] od;
    } vec_t;

    vec_t        vq[$];
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] mq[$];
    logic [63:0] last_out;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic iv, input logic [31:0] d, input logic ordy,
                       input logic fl, input logic ov, input logic ir, input logic [1:0] occ,
                       input logic [31:0] od);
        vec_t v;
        v.rst_n = r; v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.ov = ov; v.ir = ir; v.occ = occ; v.od = od;
        vq.push_back(v);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        //   rst iv  data           ordy fl  | ov ir occ od
        add(0, 1, 32'hDEAD_BEEF, 0, 0,   0, 1, 0, 32'h0);
        add(0, 1, 32'hDEAD_BEEF, 0, 0,   0, 1, 0, 32'h0);
        add(1, 0, 32'h0,         0, 0,   0, 1, 0, 32'h0);
        add(1, 1, 32'h1,         1, 0,   1, 1, 1, 32'h1);
        add(1, 1, 32'h2,         1, 0,   1, 1, 1, 32'h2);
        add(1, 1, 32'h3,         1, 0,   1, 1, 1, 32'h3);
        add(1, 1, 32'h4,         1, 0,   1, 1, 1, 32'h4);
        add(1, 0, 32'h0,         1, 0,   0, 1, 0, 32'h4);
        add(1, 1, 32'hA,         0, 0,   1, 1, 1, 32'hA);
        add(1, 1, 32'hB,         0, 0,   1, 0, 2, 32'hA);
        add(1, 1, 32'hC,         0, 0,   1, 0, 2, 32'hA);
        add(1, 1, 32'hC,         1, 0,   1, 1, 1, 32'hB);
        add(1, 1, 32'hC,         1, 0,   1, 1, 1, 32'hC);
        add(1, 0, 32'h0,         1, 0,   0, 1, 0, 32'hC);
        add(1, 1, 32'h11,        0, 0,   1, 1, 1, 32'h11);
        add(1, 1, 32'h22,        0, 0,   1, 0, 2, 32'h11);
        add(1, 1, 32'h33,        0, 1,   0, 1, 0, 32'h11);
        add(1, 0, 32'h0,         1, 0,   0, 1, 0, 32'h11);
        add(1, 1, 32'h5,         0, 0,   1, 1, 1, 32'h5);
        add(1, 1, 32'h6,         1, 0,   1, 1, 1, 32'h6);
        add(1, 0, 32'h0,         0, 0,   1, 1, 1, 32'h6);
        add(1, 0, 32'h0,         1, 0,   0, 1, 0, 32'h6);
        add(1, 1, 32'h7,         0, 0,   1, 1, 1, 32'h7);
        add(1, 1, 32'h8,         1, 1,   0, 1, 0, 32'h7);
        add(1, 1, 32'h9,         0, 0,   1, 1, 1, 32'h9);
        add(1, 1, 32'hA0,        0, 0,   1, 0, 2, 32'h9);
        add(0, 1, 32'hB0,        1, 1,   0, 1, 0, 32'h0);
        add(1, 0, 32'h0,         0, 0,   0, 1, 0, 32'h0);

        #1;
        foreach (vq[i]) begin
            rst_n     = vq[i].rst_n;
            in_valid  = vq[i].iv;
            in_data   = {32'h0, vq[i].d};
            out_ready = vq[i].ordy;
            flush     = vq[i].fl;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_valid", i), {63'h0, ov32}, {63'h0, vq[i].ov});
            check($sformatf("vec%0d in_ready", i),  {63'h0, ir32}, {63'h0, vq[i].ir});
            check($sformatf("vec%0d occupancy", i), {62'h0, occ32}, {62'h0, vq[i].occ});
            check($sformatf("vec%0d out_data", i),  {32'h0, od32}, {32'h0, vq[i].od});
        end

        // Random traffic against a queue model, all three widths in lockstep.
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        last_out = '0;
        for (int c = 0; c < 10000 && failures <= 20; c++) begin
            logic m_acc;
            logic m_pop;
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 60);
            flush     = ($urandom_range(0, 99) < 3);
            in_data   = {$urandom, $urandom};
            m_acc     = in_valid && (mq.size() < 2);
            m_pop     = (mq.size() > 0) && out_ready;
            @(posedge clk);
            #1;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_acc) mq.push_back(in_data);
            end
            if (mq.size() > 0) last_out = mq[0];
            check("rnd w32 out_valid", {63'h0, ov32}, {63'h0, mq.size() > 0});
            check("rnd w32 in_ready",  {63'h0, ir32}, {63'h0, mq.size() < 2});
            check("rnd w32 occupancy", {62'h0, occ32}, 64'(mq.size()));
            check("rnd w32 out_data",  {32'h0, od32}, {32'h0, last_out[31:0]});
            check("rnd w1 out_valid",  {63'h0, ov1}, {63'h0, mq.size() > 0});
            check("rnd w1 in_ready",   {63'h0, ir1}, {63'h0, mq.size() < 2});
            check("rnd w1 occupancy",  {62'h0, occ1}, 64'(mq.size()));
            check("rnd w1 out_data",   {63'h0, od1}, {63'h0, last_out[0]});
            check("rnd w64 out_valid", {63'h0, ov64}, {63'h0, mq.size() > 0});
            check("rnd w64 in_ready",  {63'h0, ir64}, {63'h0, mq.size() < 2});
            check("rnd w64 occupancy", {62'h0, occ64}, 64'(mq.size()));
            check("rnd w64 out_data",  od64, last_out);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, meaning the payload width in bits (for example, a packed aluresult/memread/rd/control bundle).
REQ-002 The block SHALL take parameter RESET_VAL, default 0, meaning the value loaded into both data registers on reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream presents a payload.
REQ-006 The block SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the stage accepts a payload this cycle; driven directly from a register.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid payload.
REQ-009 The block SHALL have port out_data, output, DATA_W bits: downstream payload; driven directly from a register.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream consumes the payload this cycle.
REQ-011 The block SHALL have port flush, input, 1 bit: discard all held payloads; highest priority.
REQ-012 The block SHALL have port occupancy, output, 2 bits: number of payloads held, 0 to 2.

Function
REQ-013 An accept SHALL occur when in_valid and in_ready are both 1; a pop SHALL occur when out_valid and out_ready are both 1.
REQ-014 The block SHALL hold two registers, main and skid, and SHALL implement three states: EMPTY (occupancy 0), BUSY (occupancy 1), FULL (occupancy 2).
REQ-015 out_valid SHALL be 1 in BUSY and FULL; out_data SHALL always equal main.
REQ-016 in_ready SHALL be 1 in EMPTY and BUSY, and 0 in FULL.
REQ-017 EMPTY with an accept SHALL load main with in_data and move to BUSY; with no accept, the block SHALL stay in EMPTY.
REQ-018 BUSY with an accept and no pop SHALL load skid with in_data and move to FULL.
REQ-019 BUSY with a pop and no accept SHALL move to EMPTY.
REQ-020 BUSY with both an accept and a pop SHALL load main with in_data and stay in BUSY, giving full throughput of one payload per cycle.
REQ-021 FULL with a pop SHALL copy skid into main and move to BUSY; with no pop, the block SHALL hold both registers.
REQ-022 Latency from accept to out_valid SHALL be exactly 1 cycle when the stage was EMPTY, or BUSY with a simultaneous pop.
REQ-023 Payload order SHALL be strictly FIFO; no payload SHALL be duplicated or lost except by flush.
REQ-024 When flush is 1, the next state SHALL be EMPTY, regardless of an accept or pop in the same cycle.
REQ-025 A payload accepted in a flush cycle SHALL be dropped, but upstream treats it as consumed; a payload popped in a flush cycle counts as delivered.
REQ-026 out_data SHALL hold its last value while out_valid is 0.
REQ-027 The data registers SHALL update only on the loads listed above, with no other toggling, to save power.
REQ-028 While out_valid is 1 and no pop occurs, out_data and out_valid SHALL remain stable until a pop or a flush.

Reset
REQ-029 When rst_n is 0 at posedge clk, the block SHALL go to EMPTY with out_valid=0, in_ready=1, occupancy=0, and main=skid=RESET_VAL.
REQ-030 A reset asserted mid-transfer SHALL discard all held payloads, with the same priority as flush; reset SHALL dominate flush.
REQ-031 The block SHALL contain no asynchronous reset paths.

Structure
REQ-032 The state encoding (EMPTY/BUSY/FULL) and the default DATA_W SHALL live in the shared package pipe_pkg.
REQ-033 The data path SHALL instantiate the sub-module pipe_en_reg twice, one each for main and skid; pipe_en_reg is a DATA_W-wide register with load enable and synchronous active-low reset.
REQ-034 Existing fixed stage registers SHALL be replaceable by pipe_skid_reg with out_ready tied to 1 and flush tied to 0.

Verification
REQ-035 Scenario (reset): hold rst_n=0 for 2 cycles with in_valid=1 and in_data=32'hDEAD_BEEF -> after release, out_valid=0, occupancy=0, in_ready=1, out_data=0.
REQ-036 Scenario (streaming): send 1, 2, 3, 4 on consecutive cycles with out_ready=1 -> out_data shows 1, 2, 3, 4 on consecutive cycles, each 1 cycle after its accept; occupancy stays at 1.
REQ-037 Scenario (backpressure): send 0xA, 0xB with out_ready=0 -> occupancy=2 and in_ready=0, and 0xC is held off by upstream; raise out_ready -> 0xA, 0xB, 0xC are delivered in order with no loss.
REQ-038 Scenario (flush in FULL): hold 0x11 and 0x22, assert flush together with in_valid carrying 0x33 -> next cycle out_valid=0 and occupancy=0, and 0x33 never appears.
REQ-039 Scenario (simultaneous in BUSY): hold 0x5, pop it and accept 0x6 in the same cycle -> next cycle out_data=0x6, occupancy=1, and skid is not loaded.
REQ-040 Scenario (random): random in_valid, out_ready and flush over 10k cycles against a scoreboard -> ordering holds and occupancy never exceeds 2; the bench SHALL also run with DATA_W=1 and DATA_W=64.
